data_sram_responder: RTL and testbench

Responder end of the core's data-SRAM port (en / we[3:0] / addr / wdata, no back-pressure). It holds a word-organised, byte-writable data memory window and returns read data after a fixed, parameterised latency with a valid strobe. It checks every request for legal byte-enable/alignment and window range, and keeps access counters for the difftest bench. It sits outside the CPU, facing the EXE-stage request port and the MEM-stage read-data input.

---
 rtl/data_sram_responder.sv | 118 +++++++++++
 tb/tb_data_sram_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: byte-writable word memory window with a fixed-latency
// read return, request legality/range checking and access counters.
module data_sram_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        access_err,
    output logic [31:0] err_addr,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Storage; deliberately not reset.
    logic [31:0] mem_q [DEPTH];

    logic             in_range;
    logic             is_rd;
    logic             wr_legal;
    logic             rd_fire;
    logic             wr_fire;
    logic             req_err;
    logic [IDX_W-1:0] widx;
    logic [31:0]      rd_word;

    logic        access_err_q, access_err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    // Each stage holds its data while idle, so the last stage doubles as the
    // rdata hold register between read returns.
    logic [RD_LAT-1:0]       vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0][31:0] dat_pipe_q, dat_pipe_d;

    // Decode the request: range, alignment legality, read/write fire.
    always_comb begin
        in_range = (data_sram_addr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
        widx     = data_sram_addr[IDX_W+1:2];
        is_rd    = (data_sram_we == 4'b0000);
        case ({data_sram_addr[1:0], data_sram_we})
            6'b00_0001, 6'b01_0010, 6'b10_0100, 6'b11_1000,
            6'b00_0011, 6'b10_1100,
            6'b00_1111: wr_legal = 1'b1;
            default:    wr_legal = 1'b0;
        endcase
        rd_fire = data_sram_en && is_rd;
        wr_fire = data_sram_en && !is_rd && in_range && wr_legal;
        req_err = data_sram_en && (!in_range || (!is_rd && !wr_legal));
        // Out-of-range reads still return, carrying zero.
        rd_word = in_range ? mem_q[widx] : 32'h0;
    end

    // Byte-lane merge of legal in-range writes; requests during reset ignored.
    always_ff @(posedge clk) begin
        if (resetn && wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_we[b]) begin
                    mem_q[widx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Next state for error capture, counters and the read-return pipeline.
    always_comb begin
        access_err_d = access_err_q | req_err;
        err_addr_d   = (req_err && !access_err_q) ? data_sram_addr : err_addr_q;
        rd_cnt_d     = (rd_fire && in_range) ? rd_cnt_q + 32'd1 : rd_cnt_q;
        wr_cnt_d     = wr_fire ? wr_cnt_q + 32'd1 : wr_cnt_q;

        vld_pipe_d    = vld_pipe_q;
        dat_pipe_d    = dat_pipe_q;
        vld_pipe_d[0] = rd_fire;
        dat_pipe_d[0] = rd_fire ? rd_word : dat_pipe_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            dat_pipe_d[i] = vld_pipe_q[i-1] ? dat_pipe_q[i-1] : dat_pipe_q[i];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            access_err_q <= 1'b0;
            err_addr_q   <= 32'h0;
            rd_cnt_q     <= 32'h0;
            wr_cnt_q     <= 32'h0;
            vld_pipe_q   <= '0;
            dat_pipe_q   <= '0;
        end else begin
            access_err_q <= access_err_d;
            err_addr_q   <= err_addr_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            vld_pipe_q   <= vld_pipe_d;
            dat_pipe_q   <= dat_pipe_d;
        end
    end

    assign data_sram_rdata = dat_pipe_q[RD_LAT-1];
    assign rdata_valid     = vld_pipe_q[RD_LAT-1];
    assign access_err      = access_err_q;
    assign err_addr        = err_addr_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (read latency 1, 2, 3) share
// one stimulus stream and are checked every cycle against a transaction model.
module tb_data_sram_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          WIN   = DEPTH * 4;
    localparam int          NL    = 3;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rdata_w  [NL];
    logic        vld_w    [NL];
    logic        err_w    [NL];
    logic [31:0] eaddr_w  [NL];
    logic [31:0] rdcnt_w  [NL];
    logic [31:0] wrcnt_w  [NL];

    for (genvar g = 0; g < NL; g++) begin : g_dut
        data_sram_responder #(
            .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(g + 1)
        ) u_dut (
            .clk             (clk),
            .resetn          (resetn),
            .data_sram_en    (en),
            .data_sram_we    (we),
            .data_sram_addr  (addr),
            .data_sram_wdata (wdata),
            .data_sram_rdata (rdata_w[g]),
            .rdata_valid     (vld_w[g]),
            .access_err      (err_w[g]),
            .err_addr        (eaddr_w[g]),
            .rd_cnt          (rdcnt_w[g]),
            .wr_cnt          (wrcnt_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          ret_v [NL][8];   // returns scheduled by due cycle (ring)
    logic [31:0] ret_d [NL][8];
    logic [31:0] m_rdata [NL];
    bit          m_vld [NL];
    bit          m_err;
    logic [31:0] m_eaddr;
    logic [31:0] m_rd, m_wr;
    int          cyc = 0;

    // Legal iff a naturally aligned contiguous 1/2/4-byte lane group.
    function automatic bit legal(input logic [3:0] w, input logic [1:0] off);
        int sz;
        int mask;
        sz = $countones(w);
        if (!(sz == 1 || sz == 2 || sz == 4)) return 1'b0;
        if ((int'(off) % sz) != 0) return 1'b0;
        mask = ((1 << sz) - 1) << off;
        return w == mask[3:0];
    endfunction

    task automatic model_edge(input bit e, input logic [3:0] w, input logic [31:0] a,
                              input logic [31:0] wd, input bit rst);
        bit          inr;
        bit          bad;
        int          idx;
        logic [31:0] rv;
        if (rst) begin
            for (int k = 0; k < NL; k++) begin
                m_rdata[k] = 32'h0;
                m_vld[k]   = 1'b0;
                for (int d = 0; d < 8; d++) ret_v[k][d] = 1'b0;
            end
            m_err = 1'b0; m_eaddr = 32'h0; m_rd = 32'h0; m_wr = 32'h0;
        end else begin
            if (e) begin
                inr = (a / WIN) == (BASE / WIN);
                idx = int'((a % WIN) / 4);
                bad = !inr;
                if (w == 4'b0000) begin
                    rv = inr ? m_mem[idx] : 32'h0;
                    for (int k = 0; k < NL; k++) begin
                        ret_v[k][(cyc + k) % 8] = 1'b1;
                        ret_d[k][(cyc + k) % 8] = rv;
                    end
                    if (inr) m_rd++;
                end else if (inr && legal(w, a[1:0])) begin
                    for (int b = 0; b < 4; b++)
                        if (w[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
                    m_wr++;
                end else begin
                    bad = 1'b1;
                end
                if (bad) begin
                    if (!m_err) m_eaddr = a;
                    m_err = 1'b1;
                end
            end
            for (int k = 0; k < NL; k++) begin
                m_vld[k] = ret_v[k][cyc % 8];
                if (m_vld[k]) m_rdata[k] = ret_d[k][cyc % 8];
                ret_v[k][cyc % 8] = 1'b0;
            end
        end
        cyc++;
    endtask

    // One clock: drive, let the edge happen, update model, compare mid-cycle.
    task automatic step(input bit e, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] wd, input bit rst);
        en = e; we = w; addr = a; wdata = wd; resetn = !rst;
        @(posedge clk);
        model_edge(e, w, a, wd, rst);
        @(negedge clk);
        for (int k = 0; k < NL; k++) begin
            chk($sformatf("vld%0d", k),   {31'h0, vld_w[k]}, {31'h0, m_vld[k]});
            chk($sformatf("rdata%0d", k), rdata_w[k], m_rdata[k]);
            chk($sformatf("err%0d", k),   {31'h0, err_w[k]}, {31'h0, m_err});
            chk($sformatf("eaddr%0d", k), eaddr_w[k], m_eaddr);
            chk($sformatf("rdcnt%0d", k), rdcnt_w[k], m_rd);
            chk($sformatf("wrcnt%0d", k), wrcnt_w[k], m_wr);
        end
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 4'b0000, a, $urandom, 1'b0);
    endtask
    task automatic wr(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        step(1'b1, w, a, d, 1'b0);
    endtask
    task automatic idle();
        step(1'b0, 4'($urandom), $urandom, $urandom, 1'b0);
    endtask

    logic [3:0] we_tab [7];
    logic [3:0] rw;
    logic [31:0] ra;
    int r;

    initial begin
        we_tab[0] = 4'b0001; we_tab[1] = 4'b0010; we_tab[2] = 4'b0100; we_tab[3] = 4'b1000;
        we_tab[4] = 4'b0011; we_tab[5] = 4'b1100; we_tab[6] = 4'b1111;

        // reset state
        step(1'b1, 4'b1111, 32'h10, 32'h1, 1'b1);
        step(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
        chk("reset_rdata", rdata_w[0], 32'h0);

        // fill memory so every later read has a defined expectation
        for (int i = 0; i < DEPTH; i++) wr(4'b1111, i * 4, $urandom);
        chk("fill_wrcnt", wrcnt_w[0], 32'(DEPTH));

        // word write then read
        wr(4'b1111, 32'h10, 32'hDEAD_BEEF);
        rd(32'h10);
        chk("wr_rd_data", rdata_w[0], 32'hDEAD_BEEF);
        chk("wr_rd_vld", {31'h0, vld_w[0]}, 32'h1);
        idle();
        chk("wr_rd_pulse", {31'h0, vld_w[0]}, 32'h0);
        chk("wr_rd_hold", rdata_w[0], 32'hDEAD_BEEF);

        // byte and half merge
        wr(4'b0100, 32'h12, 32'h5A5A_5A5A);
        wr(4'b0011, 32'h10, 32'h1234_1234);
        rd(32'h10);
        chk("merge_data", rdata_w[0], 32'hDE5A_1234);

        // cancelled store is a read
        step(1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, 1'b0);
        chk("cancel_data", rdata_w[0], 32'hDE5A_1234);

        // latency / streaming, then overwrite word 0 behind the reads
        rd(32'h0); rd(32'h4); rd(32'h8);
        wr(4'b1111, 32'h0, 32'h0);
        repeat (4) idle();
        rd(32'h0);
        chk("after_ovw", rdata_w[0], 32'h0);

        // misaligned write, then out-of-range read
        wr(4'b0011, 32'h11, 32'hFFFF_FFFF);
        chk("mis_err", {31'h0, err_w[0]}, 32'h1);
        chk("mis_eaddr", eaddr_w[0], 32'h11);
        rd(BASE + WIN);
        chk("oor_data", rdata_w[0], 32'h0);
        chk("oor_vld", {31'h0, vld_w[0]}, 32'h1);
        chk("oor_eaddr", eaddr_w[0], 32'h11);
        rd(32'h10);
        chk("mis_unchanged", rdata_w[0], 32'hDE5A_1234);

        // reset with reads in flight
        rd(32'h10);
        step(1'b1, 4'b0000, 32'h14, 32'h0, 1'b1);
        repeat (3) idle();
        rd(32'h10);
        chk("post_rst_mem", rdata_w[0], 32'hDE5A_1234);

        // randomized traffic, including random resets
        for (int n = 0; n < 700; n++) begin
            r  = $urandom_range(99);
            rw = ($urandom_range(9) < 4) ? 4'b0000 :
                 ($urandom_range(7) == 0) ? 4'($urandom) : we_tab[$urandom_range(6)];
            ra = ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(WIN - 1));
            step(r < 80, rw, ra, $urandom, r == 99);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
